// File: rtl/systolic_ctrl_pkg.sv
// Shared definitions for the systolic wrapper host-side controller:
// wrapper register map and the job sequencer state encoding.
package systolic_ctrl_pkg;

  // Wrapper register map (byte addresses on the 6-bit wrapper bus)
  localparam int A_BASE      = 0;
  localparam int A_BYTES     = 32;
  localparam int B_BASE      = 32;
  localparam int B_BYTES     = 16;
  localparam int RES_BASE    = 48;
  localparam int RES_WIN     = 15;
  localparam int STATUS_ADDR = 63;

  // Operand stream length: matrix A followed directly by matrix B
  localparam int OPND_BYTES  = A_BYTES + B_BYTES;

  // Job sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    KICK   = 3'd2,
    WAIT   = 3'd3,
    SETTLE = 3'd4,
    READ   = 3'd5,
    PUSH   = 3'd6
  } seq_state_t;

endpackage : systolic_ctrl_pkg

// File: rtl/systolic_job_sequencer.sv
// Host-side job sequencer for the 4x4 systolic wrapper. Writes a 48-byte
// operand stream into the wrapper map, pulses start, waits for done under a
// timeout, then reads the result window one byte at a time and streams it out.
//
// Handshakes: both byte streams use valid/ready. A byte moves on a rising clk
// edge where valid and ready are both high; valid never depends on ready, and
// once out_valid is raised out_data/out_last hold until the transfer happens.
module systolic_job_sequencer
  import systolic_ctrl_pkg::*;
#(
  parameter int RES_BYTES      = 15,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  // operand byte stream
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  // result byte stream
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  // status
  input  logic             err_clr,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] job_count,
  // wrapper pins
  output logic [7:0]       sa_data_in,
  output logic [5:0]       sa_addr,
  output logic             sa_write_en,
  output logic             sa_read_en,
  output logic             sa_start,
  input  logic [7:0]       sa_data_out,
  input  logic             sa_ready,
  input  logic             sa_done
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  seq_state_t       state_q, state_d;
  logic [5:0]       byte_cnt_q;
  logic [3:0]       res_idx_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [7:0]       out_data_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] job_count_q;

  logic in_fire;     // operand byte accepted this cycle
  logic out_fire;    // result byte accepted this cycle
  logic res_last;    // current result byte is the final one of the job
  logic tmo_fire;    // WAIT expired without done

  assign busy        = (state_q != IDLE);
  assign out_data    = out_data_q;
  assign timeout_err = timeout_err_q;
  assign job_count   = job_count_q;

  // Next-state logic and all strobes decoded from the current state
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    sa_write_en = 1'b0;
    sa_read_en  = 1'b0;
    sa_start    = 1'b0;
    sa_addr     = 6'd0;
    sa_data_in  = 8'd0;
    in_fire     = 1'b0;
    out_fire    = 1'b0;
    res_last    = (res_idx_q == 4'(RES_BYTES - 1));
    tmo_fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sa_ready) state_d = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_fire     = 1'b1;
          sa_write_en = 1'b1;
          sa_addr     = byte_cnt_q;
          sa_data_in  = in_data;
          if (byte_cnt_q == 6'(OPND_BYTES - 1)) state_d = KICK;
        end
      end
      KICK: begin
        sa_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        // done is checked first so a done on the last allowed cycle still wins
        if (sa_done) begin
          state_d = SETTLE;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      SETTLE: begin
        state_d = READ;
      end
      READ: begin
        sa_read_en = 1'b1;
        sa_addr    = 6'(RES_BASE) + 6'(res_idx_q);
        state_d    = PUSH;
      end
      PUSH: begin
        out_valid = 1'b1;
        out_last  = res_last;
        if (out_ready) begin
          out_fire = 1'b1;
          state_d  = res_last ? IDLE : READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand byte counter: doubles as the write address during LOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                byte_cnt_q <= 6'd0;
    else if (state_q != LOAD) byte_cnt_q <= 6'd0;
    else if (in_fire)       byte_cnt_q <= byte_cnt_q + 6'd1;
  end

  // Timeout counter: cleared on the start pulse, counts every WAIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  tmo_cnt_q <= '0;
    else if (state_q == KICK) tmo_cnt_q <= '0;
    else if (state_q == WAIT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  // Result index: restarts after the settle cycle, advances per delivered byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       res_idx_q <= 4'd0;
    else if (state_q == SETTLE)    res_idx_q <= 4'd0;
    else if (out_fire && !res_last) res_idx_q <= res_idx_q + 4'd1;
  end

  // Result byte register: captures the combinational wrapper read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  out_data_q <= 8'd0;
    else if (state_q == READ) out_data_q <= sa_data_out;
  end

  // Sticky timeout flag: a new timeout takes priority over a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          timeout_err_q <= 1'b0;
    else if (tmo_fire) timeout_err_q <= 1'b1;
    else if (err_clr) timeout_err_q <= 1'b0;
  end

  // Completed-job counter: bumps when the final result byte is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       job_count_q <= '0;
    else if (out_fire && res_last) job_count_q <= job_count_q + 1'b1;
  end

endmodule : systolic_job_sequencer

// File: tb/tb_systolic_job_sequencer.sv
// Bench for systolic_job_sequencer. A behavioural wrapper stand-in holds the
// 64-byte register map and exposes row 0 of A*B (four 32-bit little-endian
// sums) in the result window. Expected result bytes come from the operand
// bytes by plain arithmetic; wrapper-pin traffic is logged and checked.
module tb_systolic_job_sequencer;

  localparam int RES_BYTES      = 15;
  localparam int TIMEOUT_CYCLES = 256;
  localparam int CNT_W          = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             in_valid = 1'b0;
  logic [7:0]       in_data  = 8'd0;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic             err_clr   = 1'b0;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] job_count;
  logic [7:0]       sa_data_in;
  logic [5:0]       sa_addr;
  logic             sa_write_en;
  logic             sa_read_en;
  logic             sa_start;
  logic [7:0]       sa_data_out;
  logic             sa_ready;
  logic             sa_done;

  systolic_job_sequencer #(
    .RES_BYTES(RES_BYTES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready),
    .err_clr(err_clr), .busy(busy), .timeout_err(timeout_err),
    .job_count(job_count),
    .sa_data_in(sa_data_in), .sa_addr(sa_addr), .sa_write_en(sa_write_en),
    .sa_read_en(sa_read_en), .sa_start(sa_start), .sa_data_out(sa_data_out),
    .sa_ready(sa_ready), .sa_done(sa_done)
  );

  // ---------------- wrapper stand-in ----------------
  // mode 0: done after m_delay cycles; 1: never done; 2: done on the last WAIT cycle
  logic [7:0] wmem [64];
  int         mock_mode  = 0;
  int         m_delay    = 0;
  logic       mock_abort = 1'b0;
  logic       m_busy;
  int         m_cnt;

  assign sa_ready    = !m_busy;
  assign sa_data_out = sa_read_en ? wmem[sa_addr] : 8'h00;

  // Register-map writes, start/done handshake and the row-0 product
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      sa_done <= 1'b0;
    end else begin
      if (sa_write_en) wmem[sa_addr] <= sa_data_in;
      if (sa_start) begin
        m_busy  <= 1'b1;
        m_cnt   <= 0;
        sa_done <= 1'b0;
      end else if (mock_abort) begin
        m_busy <= 1'b0;
      end else if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if ((mock_mode == 0 && m_cnt == m_delay) ||
            (mock_mode == 2 && m_cnt == TIMEOUT_CYCLES - 2)) begin
          for (int k = 0; k < 4; k++) begin
            logic [31:0] acc;
            acc = 32'd0;
            for (int j = 0; j < 4; j++)
              acc = acc + {wmem[2*j+1], wmem[2*j]} * {24'd0, wmem[32 + 4*j + k]};
            for (int b = 0; b < 4; b++)
              if (4*k + b < 15) wmem[48 + 4*k + b] <= acc[8*b +: 8];
          end
          sa_done <= 1'b1;
          m_busy  <= 1'b0;
        end
      end
    end
  end

  // ---------------- pin monitor ----------------
  int         cyc = 0;
  int         n_start = 0, n_read = 0, n_outv = 0, start_cyc = 0;
  logic [5:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];

  always @(posedge clk) cyc++;

  // Log wrapper traffic mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (sa_write_en) begin
        wr_addr_q.push_back(sa_addr);
        wr_data_q.push_back(sa_data_in);
      end
      if (sa_start) begin
        n_start++;
        start_cyc = cyc;
      end
      if (sa_read_en) n_read++;
      if (out_valid)  n_outv++;
    end
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  int         exp_jobs = 0;
  logic [7:0] op [48];
  logic [7:0] exp_q[$];
  logic [7:0] id_exp [15] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                              8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Sample point: mid-cycle, after the monitor has logged this cycle
  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Expected stream: row 0 of A*B as four 32-bit little-endian sums, truncated
  task automatic build_expected();
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      int sum;
      sum = 0;
      for (int j = 0; j < 4; j++)
        sum += (int'(op[2*j+1]) * 256 + int'(op[2*j])) * int'(op[32 + 4*j + k]);
      for (int b = 0; b < 4; b++)
        if (exp_q.size() < RES_BYTES) exp_q.push_back(8'((sum >> (8*b)) & 255));
    end
  endtask

  // ---------------- drivers ----------------
  // mode 0: in_valid always high; 1: alternating 1-0-1; 2: random gaps
  task automatic drive_operands(input int mode, input int nbytes);
    int i = 0;
    int guard = 0;
    bit v;
    while (i < nbytes && guard < 600) begin
      @(posedge clk);
      #1;
      case (mode)
        1:       v = (guard % 2 == 0);
        2:       v = ($urandom_range(0, 2) != 0);
        default: v = 1'b1;
      endcase
      in_valid = v;
      in_data  = v ? op[i] : 8'($urandom_range(0, 255));
      sample();
      if (v && in_ready) i++;
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (i < nbytes) check("load_budget", i, nbytes);
  endtask

  // Drains one job's result stream; optionally stalls byte stall_byte for 10 cycles
  task automatic consume(input int stall_byte, input bit rand_rdy);
    int         n = 0, guard = 0, stall_cnt = 0, snap_reads = 0;
    bit         seen = 1'b0, rdy, done = 1'b0;
    logic [7:0] snap = 8'd0, e;
    while (!done && guard < 3000) begin
      @(posedge clk);
      #1;
      if (n == stall_byte && stall_cnt < 10) rdy = 1'b0;
      else if (rand_rdy)                     rdy = ($urandom_range(0, 3) != 0);
      else                                   rdy = 1'b1;
      out_ready = rdy;
      sample();
      guard++;
      if (out_valid) begin
        if (!seen) begin
          seen       = 1'b1;
          snap       = out_data;
          snap_reads = n_read;
        end else begin
          check("hold_data", out_data, snap);
          check("no_extra_read", n_read, snap_reads);
        end
        if (rdy) begin
          e = 8'hxx;
          if (exp_q.size() > 0) e = exp_q.pop_front();
          check("out_data", out_data, e);
          check("out_last", out_last, (n == RES_BYTES - 1));
          n++;
          seen = 1'b0;
          if (out_last || n >= RES_BYTES) done = 1'b1;
        end else begin
          stall_cnt++;
        end
      end else if (seen) begin
        check("valid_held", out_valid, 1'b1);
        seen = 1'b0;
      end
    end
    if (!done) check("out_budget", n, RES_BYTES);
    check("byte_count", n, RES_BYTES);
    if (stall_byte >= 0) check("stall_cycles", stall_cnt, 10);
    // the final transfer completes on the next edge; busy must drop right after
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    sample();
    if (done) exp_jobs++;
    check("busy_after_last", busy, 1'b0);
    check("job_count", job_count, exp_jobs);
  endtask

  // One complete job with the given operand and result-side traffic shapes
  task automatic run_job(input int in_mode, input int stall_byte, input bit rand_rdy,
                         input bit identity);
    int wr_base, start_base, read_base;
    if (identity) begin
      foreach (op[i]) op[i] = 8'd0;
      for (int d = 0; d < 4; d++) op[2 * (5*d)] = 8'd1;
      for (int b = 0; b < 16; b++) op[32 + b] = 8'(b + 1);
      exp_q.delete();
      foreach (id_exp[i]) exp_q.push_back(id_exp[i]);
    end else begin
      foreach (op[i]) op[i] = 8'($urandom_range(0, 255));
      build_expected();
    end
    m_delay    = $urandom_range(0, 30);
    wr_base    = wr_addr_q.size();
    start_base = n_start;
    read_base  = n_read;
    fork
      drive_operands(in_mode, 48);
      consume(stall_byte, rand_rdy);
    join
    check("wr_count", wr_addr_q.size() - wr_base, 48);
    for (int i = 0; i < 48; i++) begin
      if (wr_base + i < wr_addr_q.size()) begin
        check("wr_addr", wr_addr_q[wr_base + i], i);
        check("wr_data", wr_data_q[wr_base + i], op[i]);
      end
    end
    check("start_pulses", n_start - start_base, 1);
    check("read_strobes", n_read - read_base, RES_BYTES);
    check("no_timeout", timeout_err, 1'b0);
  endtask

  // Job whose wrapper never finishes
  task automatic timeout_job();
    int start_base, outv_base, guard, t_err;
    mock_mode  = 1;
    foreach (op[i]) op[i] = 8'($urandom_range(0, 255));
    start_base = n_start;
    outv_base  = n_outv;
    drive_operands(0, 48);
    guard = 0;
    while (n_start == start_base && guard < 100) begin
      sample();
      guard++;
    end
    check("tmo_start_seen", n_start - start_base, 1);
    guard = 0;
    while (!timeout_err && guard < 600) begin
      sample();
      guard++;
    end
    t_err = cyc;
    check("tmo_flag", timeout_err, 1'b1);
    // the flag is first visible on the cycle after the last WAIT cycle
    check("tmo_wait_cycles", t_err - start_cyc - 1, TIMEOUT_CYCLES);
    check("tmo_idle", busy, 1'b0);
    repeat (5) sample();
    check("tmo_sticky", timeout_err, 1'b1);
    check("tmo_no_output", n_outv - outv_base, 0);
    check("tmo_jobs", job_count, exp_jobs);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    sample();
    check("err_clr", timeout_err, 1'b0);
    mock_abort = 1'b1;
    @(posedge clk);
    #1;
    mock_abort = 1'b0;
    mock_mode  = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes",
          {in_ready, out_valid, out_last, busy, timeout_err, sa_write_en, sa_read_en, sa_start},
          8'd0);
    check("rst_addr", sa_addr, 6'd0);
    check("rst_wdata", sa_data_in, 8'd0);
    check("rst_out_data", out_data, 8'd0);
    check("rst_job_count", job_count, 0);
    @(negedge clk);
    rst = 1'b0;

    run_job(0, -1, 1'b0, 1'b1);          // identity job
    run_job(1, -1, 1'b0, 1'b0);          // operand valid toggling
    run_job(0, 3, 1'b0, 1'b0);           // 10-cycle stall on byte 3
    repeat (3) run_job(2, -1, 1'b1, 1'b0);
    mock_mode = 2;
    run_job(2, -1, 1'b1, 1'b0);          // done on the final timeout cycle
    mock_mode = 0;
    timeout_job();

    // reset in the middle of an operand load
    foreach (op[i]) op[i] = 8'($urandom_range(0, 255));
    drive_operands(0, 20);
    rst = 1'b1;
    #1;
    check("midrst_strobes",
          {in_ready, out_valid, out_last, busy, timeout_err, sa_write_en, sa_read_en, sa_start},
          8'd0);
    check("midrst_addr", sa_addr, 6'd0);
    check("midrst_wdata", sa_data_in, 8'd0);
    check("midrst_out_data", out_data, 8'd0);
    check("midrst_job_count", job_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    exp_jobs = 0;
    run_job(2, -1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far",
             n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_systolic_job_sequencer
